// File: rtl/ov7670_stream_pkg.sv
// rtl/ov7670_stream_pkg.sv - shared types and constants for the OV7670 stream generator
// Contents: frame state enum, test-pattern select codes, colour-bar RGB565 table.
`timescale 1ns/1ps
package ov7670_stream_pkg;

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBP,
        ACTIVE,
        VFP
    } state_t;

    typedef enum logic [1:0] {
        PAT_BARS     = 2'd0,
        PAT_GRADIENT = 2'd1,
        PAT_SOLID    = 2'd2,
        PAT_CHECKER  = 2'd3
    } pattern_t;

    // Left-to-right bar colours: white, yellow, cyan, green, magenta, red, blue, black.
    localparam logic [15:0] BAR_COLORS [8] = '{
        16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
        16'hF81F, 16'hF800, 16'h001F, 16'h0000
    };

endpackage

// File: rtl/stream_pattern_gen.sv
// rtl/stream_pattern_gen.sv - combinational RGB565 test-pattern lookup for one pixel
// Ports: x/y pixel position, frame_odd frame parity, sel/solid latched pattern
// settings, rgb resulting RGB565 pixel.
`timescale 1ns/1ps
module stream_pattern_gen
    import ov7670_stream_pkg::*;
#(
    parameter int IMG_WIDTH = 160,
    parameter int X_W       = 8
) (
    input  logic [X_W-1:0] x,
    input  logic [5:0]     y,
    input  logic           frame_odd,
    input  pattern_t       sel,
    input  logic [15:0]    solid,
    output logic [15:0]    rgb
);

    logic [2:0] bar;
    logic       checker_on;

    always_comb begin
        bar        = 3'((32'(x) * 32'd8) / 32'(IMG_WIDTH));
        // Checker squares are 8x8 pixels and swap phase every frame.
        checker_on = 1'(x >> 3) ^ y[3] ^ frame_odd;
        case (sel)
            PAT_BARS:     rgb = BAR_COLORS[bar];
            PAT_GRADIENT: rgb = {5'(x), y, 5'(x)};
            PAT_SOLID:    rgb = solid;
            default:      rgb = checker_on ? 16'hFFFF : 16'h0000;
        endcase
    end

endmodule

// File: rtl/ov7670_stream_gen.sv
// rtl/ov7670_stream_gen.sv - synthetic OV7670 RGB565 camera stream transmitter
// Ports: clk/reset (async, active-high), enable frame start gate, pattern_sel and
// solid_color pattern config, cam_pclk/cam_vsync/cam_href/cam_data camera bus,
// frame_done end-of-frame pulse, busy frame in progress.
`timescale 1ns/1ps
module ov7670_stream_gen
    import ov7670_stream_pkg::*;
#(
    parameter int IMG_WIDTH    = 160,
    parameter int IMG_HEIGHT   = 120,
    parameter int VSYNC_LINES  = 3,
    parameter int VBP_LINES    = 17,
    parameter int VFP_LINES    = 10,
    parameter int HBLANK_BYTES = 144
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [15:0] solid_color,
    output logic        cam_pclk,
    output logic        cam_vsync,
    output logic        cam_href,
    output logic [7:0]  cam_data,
    output logic        frame_done,
    output logic        busy
);

    localparam int LINE_BYTES = 2 * IMG_WIDTH + HBLANK_BYTES;
    localparam int BYTE_W     = $clog2(LINE_BYTES);
    localparam int MAX_A      = (VSYNC_LINES > VBP_LINES) ? VSYNC_LINES : VBP_LINES;
    localparam int MAX_B      = (IMG_HEIGHT > VFP_LINES) ? IMG_HEIGHT : VFP_LINES;
    localparam int MAX_LINES  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int LINE_W     = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;

    state_t              state, nxt_state;
    logic [BYTE_W-1:0]   byte_cnt, nxt_byte;
    logic [LINE_W-1:0]   line_cnt, nxt_line;
    logic [7:0]          frame_cnt;
    pattern_t            lat_sel;
    logic [15:0]         lat_solid;
    logic                frame_end;
    logic                frame_start;
    logic                nxt_href;
    logic [15:0]         rgb;

    function automatic logic [LINE_W-1:0] last_line(input state_t s);
        case (s)
            VSYNC:   return LINE_W'(VSYNC_LINES - 1);
            VBP:     return LINE_W'(VBP_LINES - 1);
            ACTIVE:  return LINE_W'(IMG_HEIGHT - 1);
            default: return LINE_W'(VFP_LINES - 1);
        endcase
    endfunction

    // Position of the byte slot that begins at the next slot edge.
    always_comb begin
        nxt_state = state;
        nxt_byte  = byte_cnt;
        nxt_line  = line_cnt;
        frame_end = 1'b0;
        if (state == IDLE) begin
            if (enable) begin
                nxt_state = VSYNC;
                nxt_byte  = '0;
                nxt_line  = '0;
            end
        end else if (byte_cnt == BYTE_W'(LINE_BYTES - 1)) begin
            nxt_byte = '0;
            if (line_cnt == last_line(state)) begin
                nxt_line = '0;
                case (state)
                    VSYNC:  nxt_state = VBP;
                    VBP:    nxt_state = ACTIVE;
                    ACTIVE: nxt_state = VFP;
                    default: begin
                        frame_end = 1'b1;
                        nxt_state = enable ? VSYNC : IDLE;
                    end
                endcase
            end else begin
                nxt_line = line_cnt + LINE_W'(1);
            end
        end else begin
            nxt_byte = byte_cnt + BYTE_W'(1);
        end
        frame_start = (nxt_state == VSYNC) && ((state == IDLE) || frame_end);
        nxt_href    = (nxt_state == ACTIVE) && (nxt_byte < BYTE_W'(2 * IMG_WIDTH));
    end

    stream_pattern_gen #(
        .IMG_WIDTH (IMG_WIDTH),
        .X_W       (BYTE_W - 1)
    ) u_pattern (
        .x         (nxt_byte[BYTE_W-1:1]),
        .y         (6'(nxt_line)),
        .frame_odd (frame_cnt[0]),
        .sel       (lat_sel),
        .solid     (lat_solid),
        .rgb       (rgb)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            byte_cnt   <= '0;
            line_cnt   <= '0;
            frame_cnt  <= '0;
            lat_sel    <= PAT_BARS;
            lat_solid  <= '0;
            cam_pclk   <= 1'b0;
            cam_vsync  <= 1'b0;
            cam_href   <= 1'b0;
            cam_data   <= '0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            cam_pclk   <= ~cam_pclk;
            frame_done <= 1'b0;
            // Slot edge: pclk falls, so the new byte is settled before the receiver's rising edge.
            if (cam_pclk) begin
                state     <= nxt_state;
                byte_cnt  <= nxt_byte;
                line_cnt  <= nxt_line;
                cam_vsync <= (nxt_state == VSYNC);
                cam_href  <= nxt_href;
                cam_data  <= nxt_href ? (nxt_byte[0] ? rgb[7:0] : rgb[15:8]) : 8'd0;
                busy      <= (nxt_state != IDLE);
                if (frame_end) begin
                    frame_done <= 1'b1;
                    frame_cnt  <= frame_cnt + 8'd1;
                end
                if (frame_start) begin
                    lat_sel   <= pattern_t'(pattern_sel);
                    lat_solid <= solid_color;
                end
            end
        end
    end

endmodule
